// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port, fixed-latency memory between the instruction-fetch
// port and the load/store port; one access in flight, data first, fetch anti-starvation.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int ST_W  = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(MEM_LAT - 1);
    localparam logic [ST_W-1:0]  STARVE_TOP = ST_W'(STARVE_MAX);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             owner_reg, owner_next;   // 1 = data port owns the access
    logic             we_reg, we_next;
    logic [ST_W-1:0]  starve_reg, starve_next;

    logic issue_ok, respond, win_d, win_if, issue;

    // Everything is qualified by rstn so outputs stay quiet while reset is held.
    always_comb begin
        respond  = rstn && (state_reg == WAIT) && (cnt_reg == '0);
        issue_ok = rstn && ((state_reg == IDLE) || (cnt_reg == '0));
        win_d    = issue_ok && d_req && (!if_req || (starve_reg != STARVE_TOP));
        win_if   = issue_ok && if_req && !win_d;
        issue    = win_d || win_if;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            owner_reg  <= 1'b0;
            we_reg     <= 1'b0;
            starve_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            owner_reg  <= owner_next;
            we_reg     <= we_next;
            starve_reg <= starve_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        owner_next  = owner_reg;
        we_next     = we_reg;
        starve_next = starve_reg;
        if (issue) begin
            state_next = WAIT;
            cnt_next   = CNT_LOAD;
            owner_next = win_d;
            we_next    = win_d && d_we;
        end else if (state_reg == WAIT) begin
            if (cnt_reg == '0)
                state_next = IDLE;
            else
                cnt_next = cnt_reg - 1'b1;
        end
        // Starvation only accrues while fetch is actually waiting.
        if (!if_req || win_if)
            starve_next = '0;
        else if (win_d && (starve_reg != STARVE_TOP))
            starve_next = starve_reg + 1'b1;
    end

    always_comb begin
        if_gnt    = win_if;
        d_gnt     = win_d;
        mem_en    = issue;
        mem_we    = win_d && d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (win_d) begin
            mem_addr  = d_addr;
            mem_wdata = d_we ? d_wdata : '0;
            mem_be    = d_we ? d_be : {BE_W{1'b1}};
        end else if (win_if) begin
            mem_addr = if_addr;
            mem_be   = {BE_W{1'b1}};
        end
        if_rvalid = respond && !owner_reg;
        d_rvalid  = respond && owner_reg;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = (d_rvalid && !we_reg) ? mem_rdata : '0;
        busy      = rstn && (state_reg == WAIT);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; three instances share stimulus and differ
// only in MEM_LAT (index k has MEM_LAT = k+1).
module tb_mem_port_arbiter;

    logic        clk;
    logic        rstn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] mem_rdata;

    logic [2:0]  if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
    logic [31:0] if_rdata [3];
    logic [31:0] d_rdata [3];
    logic [31:0] mem_addr [3];
    logic [31:0] mem_wdata [3];
    logic [3:0]  mem_be [3];

    int checks = 0;
    int errors = 0;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        mem_port_arbiter #(
            .ADDR_W(32), .DATA_W(32), .MEM_LAT(gi + 1), .STARVE_MAX(4)
        ) u_dut (
            .clk(clk), .rstn(rstn),
            .if_req(if_req), .if_addr(if_addr),
            .if_gnt(if_gnt[gi]), .if_rvalid(if_rvalid[gi]), .if_rdata(if_rdata[gi]),
            .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
            .d_gnt(d_gnt[gi]), .d_rvalid(d_rvalid[gi]), .d_rdata(d_rdata[gi]),
            .mem_en(mem_en[gi]), .mem_we(mem_we[gi]), .mem_addr(mem_addr[gi]),
            .mem_wdata(mem_wdata[gi]), .mem_be(mem_be[gi]), .mem_rdata(mem_rdata),
            .busy(busy[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0;
        d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0;
    endtask

    task automatic do_reset;
        cyc;
        rstn = 0;
        clear_inputs;
        cyc;
        cyc;
    endtask

    task automatic test_reset;
        rstn = 0; if_req = 1; d_req = 1; if_addr = 32'h10; d_addr = 32'h20;
        for (int i = 0; i < 3; i++) begin
            cyc; #2;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({if_gnt[k], d_gnt[k], mem_en[k], if_rvalid[k], d_rvalid[k], busy[k]} !== 6'b0) begin
                    errors++;
                    $display("FAIL reset_quiet lat%0d cyc%0d: got %b required 000000", k + 1, i,
                             {if_gnt[k], d_gnt[k], mem_en[k], if_rvalid[k], d_rvalid[k], busy[k]});
                end
                checks++;
                if (mem_addr[k] !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_mem_addr lat%0d: got %h required 0", k + 1, mem_addr[k]);
                end
            end
        end
        cyc; rstn = 1; #2;
        checks++;
        if (d_gnt !== 3'b111 || if_gnt !== 3'b000) begin
            errors++;
            $display("FAIL first_grant: d_gnt=%b if_gnt=%b required 111/000", d_gnt, if_gnt);
        end
        checks++;
        if (mem_addr[0] !== 32'h20) begin
            errors++;
            $display("FAIL first_grant_addr: got %h required 00000020", mem_addr[0]);
        end
        $display("test_reset: first grant after release to D");
        clear_inputs;
    endtask

    task automatic test_if_read;
        do_reset;
        cyc; rstn = 1; if_req = 1; if_addr = 32'h100; #2;
        checks++;
        if ({if_gnt[1], mem_en[1], busy[1]} !== 3'b110) begin
            errors++;
            $display("FAIL if_issue: gnt,en,busy=%b required 110", {if_gnt[1], mem_en[1], busy[1]});
        end
        checks++;
        if (mem_addr[1] !== 32'h100 || mem_be[1] !== 4'hF || mem_we[1] !== 1'b0) begin
            errors++;
            $display("FAIL if_mem_bus: addr=%h be=%h we=%b required 00000100/f/0",
                     mem_addr[1], mem_be[1], mem_we[1]);
        end
        cyc; if_req = 0; #2;
        checks++;
        if ({busy[1], if_rvalid[1]} !== 2'b10 || if_rdata[1] !== 32'h0) begin
            errors++;
            $display("FAIL if_wait: busy,rvalid=%b rdata=%h required 10/0", {busy[1], if_rvalid[1]}, if_rdata[1]);
        end
        cyc; mem_rdata = 32'hDEADBEEF; #2;
        checks++;
        if ({busy[1], if_rvalid[1]} !== 2'b11 || if_rdata[1] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL if_resp: busy,rvalid=%b rdata=%h required 11/deadbeef", {busy[1], if_rvalid[1]}, if_rdata[1]);
        end
        cyc; mem_rdata = '0; #2;
        checks++;
        if ({busy[1], if_rvalid[1]} !== 2'b00) begin
            errors++;
            $display("FAIL if_idle: busy,rvalid=%b required 00", {busy[1], if_rvalid[1]});
        end
        $display("test_if_read: IF read 0x100 on MEM_LAT=2");
    endtask

    task automatic test_priority;
        do_reset;
        cyc; rstn = 1; if_req = 1; if_addr = 32'h180; d_req = 1; d_addr = 32'h200; #2;
        checks++;
        if ({d_gnt[1], if_gnt[1]} !== 2'b10) begin
            errors++;
            $display("FAIL prio_first: d_gnt,if_gnt=%b required 10", {d_gnt[1], if_gnt[1]});
        end
        cyc; d_req = 0; #2;
        checks++;
        if ({if_gnt[1], d_rvalid[1]} !== 2'b00) begin
            errors++;
            $display("FAIL prio_wait: if_gnt,d_rvalid=%b required 00", {if_gnt[1], d_rvalid[1]});
        end
        cyc; mem_rdata = 32'h0000A5A5; #2;
        checks++;
        if ({d_rvalid[1], if_gnt[1], if_rvalid[1]} !== 3'b110 || d_rdata[1] !== 32'h0000A5A5) begin
            errors++;
            $display("FAIL prio_b2b: d_rvalid,if_gnt,if_rvalid=%b d_rdata=%h required 110/0000a5a5",
                     {d_rvalid[1], if_gnt[1], if_rvalid[1]}, d_rdata[1]);
        end
        checks++;
        if (mem_addr[1] !== 32'h180) begin
            errors++;
            $display("FAIL prio_b2b_addr: got %h required 00000180", mem_addr[1]);
        end
        cyc; if_req = 0; mem_rdata = 32'h11112222; #2;
        cyc; #2;
        checks++;
        if (if_rvalid[1] !== 1'b1 || if_rdata[1] !== 32'h11112222) begin
            errors++;
            $display("FAIL prio_if_resp: rvalid=%b rdata=%h required 1/11112222", if_rvalid[1], if_rdata[1]);
        end
        mem_rdata = '0;
        $display("test_priority: D first, IF issued in D response cycle");
    endtask

    task automatic test_starvation;
        logic [6:0] exp_d;
        exp_d = 7'b1101111;   // bit i = D expected in cycle i: D,D,D,D,IF,D,D
        do_reset;
        cyc; rstn = 1; if_req = 1; d_req = 1; if_addr = 32'h300; d_addr = 32'h304; #2;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) begin
                cyc; #2;
            end
            checks++;
            if ({d_gnt[0], if_gnt[0]} !== {exp_d[i], ~exp_d[i]}) begin
                errors++;
                $display("FAIL starve_grant cyc%0d: d_gnt,if_gnt=%b required %b", i,
                         {d_gnt[0], if_gnt[0]}, {exp_d[i], ~exp_d[i]});
            end
            if (i > 0) begin
                checks++;
                if ({if_rvalid[0], d_rvalid[0]} !== {~exp_d[i-1], exp_d[i-1]}) begin
                    errors++;
                    $display("FAIL starve_rvalid cyc%0d: if_rvalid,d_rvalid=%b required %b", i,
                             {if_rvalid[0], d_rvalid[0]}, {~exp_d[i-1], exp_d[i-1]});
                end
            end
            $display("test_starvation cyc%0d: d_gnt=%b if_gnt=%b", i, d_gnt[0], if_gnt[0]);
        end
        clear_inputs;
    endtask

    task automatic test_write;
        do_reset;
        cyc; rstn = 1; d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h12345678;
        d_be = 4'b0011; mem_rdata = 32'hFFFFFFFF; #2;
        checks++;
        if ({d_gnt[1], mem_en[1], mem_we[1]} !== 3'b111 || mem_be[1] !== 4'b0011) begin
            errors++;
            $display("FAIL wr_issue: gnt,en,we=%b be=%b required 111/0011",
                     {d_gnt[1], mem_en[1], mem_we[1]}, mem_be[1]);
        end
        checks++;
        if (mem_wdata[1] !== 32'h12345678 || mem_addr[1] !== 32'h40) begin
            errors++;
            $display("FAIL wr_bus: wdata=%h addr=%h required 12345678/00000040", mem_wdata[1], mem_addr[1]);
        end
        cyc; d_req = 0; d_we = 0; #2;
        cyc; #2;
        checks++;
        if (d_rvalid[1] !== 1'b1 || d_rdata[1] !== 32'h0) begin
            errors++;
            $display("FAIL wr_ack: rvalid=%b rdata=%h required 1/0", d_rvalid[1], d_rdata[1]);
        end
        mem_rdata = '0;
        $display("test_write: write 0x40 be=0011 acked");
    endtask

    task automatic test_reset_mid;
        do_reset;
        cyc; rstn = 1; if_req = 1; if_addr = 32'h300; #2;
        checks++;
        if (if_gnt[2] !== 1'b1) begin
            errors++;
            $display("FAIL midrst_issue: if_gnt=%b required 1", if_gnt[2]);
        end
        cyc; if_req = 0; rstn = 0; mem_rdata = 32'hCAFEF00D; #2;
        checks++;
        if (busy[2] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_busy_held: busy=%b required 0", busy[2]);
        end
        cyc; rstn = 1; #2;
        checks++;
        if ({busy[2], if_rvalid[2]} !== 2'b00) begin
            errors++;
            $display("FAIL midrst_after: busy,rvalid=%b required 00", {busy[2], if_rvalid[2]});
        end
        cyc; #2;
        checks++;
        if ({busy[2], if_rvalid[2]} !== 2'b00 || if_rdata[2] !== 32'h0) begin
            errors++;
            $display("FAIL midrst_no_resp: busy,rvalid=%b rdata=%h required 00/0", {busy[2], if_rvalid[2]}, if_rdata[2]);
        end
        cyc; d_req = 1; d_addr = 32'h44; mem_rdata = 32'h0BADF00D; #2;
        checks++;
        if (d_gnt[2] !== 1'b1) begin
            errors++;
            $display("FAIL midrst_new_gnt: d_gnt=%b required 1", d_gnt[2]);
        end
        cyc; d_req = 0; #2;
        checks++;
        if ({busy[2], d_rvalid[2]} !== 2'b10) begin
            errors++;
            $display("FAIL midrst_new_wait: busy,rvalid=%b required 10", {busy[2], d_rvalid[2]});
        end
        cyc; #2;
        cyc; #2;
        checks++;
        if (d_rvalid[2] !== 1'b1 || d_rdata[2] !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL midrst_new_resp: rvalid=%b rdata=%h required 1/0badf00d", d_rvalid[2], d_rdata[2]);
        end
        $display("test_reset_mid: access dropped, new read served on MEM_LAT=3");
    endtask

    initial begin
        rstn = 0;
        clear_inputs;
        test_reset;
        test_if_read;
        test_priority;
        test_starvation;
        test_write;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
